// File: rtl/rr_arbiter_n.sv
// rr_arbiter_n: N-way round-robin arbiter with a registered one-hot grant and owner lock.
// Define ARB_HOLD_TIMEOUT_EN to bound a locked owner's tenure to MAX_HOLD cycles while others wait.
module rr_arbiter_n #(
  parameter  int N_REQ    = 4,
  parameter  int MAX_HOLD = 16,
  localparam int IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] lock,
  output logic [N_REQ-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t           state_q;
  logic [N_REQ-1:0] grant_q;
  logic             valid_q;
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] ptr_q;

  logic             others;
  logic             force_rot;
  logic             keep;
  logic [N_REQ-1:0] req_m;
  logic             found;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] win_d;
  logic [IDX_W-1:0] ptr_d;

  // grant_q is zero when idle, so these terms only see the current owner
  assign others = |(req & ~grant_q);
  assign keep   = (|(req & lock & grant_q)) & ~force_rot;
  assign req_m  = force_rot ? (req & ~grant_q) : req;

`ifdef ARB_HOLD_TIMEOUT_EN
  localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  logic [HC_W-1:0] hold_q;

  assign force_rot = (hold_q == HOLD_LAST) && others;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (state_q == OWNED && keep) begin
      if (hold_q != HOLD_LAST) hold_q <= hold_q + 1'b1;
    end else begin
      hold_q <= '0;
    end
  end
`else
  logic [31:0] unused_max_hold;

  assign unused_max_hold = MAX_HOLD;
  assign force_rot       = 1'b0;
`endif

  // Scan from the priority pointer; the owner sits last in the order since ptr = owner+1
  always_comb begin
    found = 1'b0;
    cand  = '0;
    win_d = idx_q;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!found && req_m[cand]) begin
        found = 1'b1;
        win_d = cand;
      end
    end
    ptr_d = IDX_W'((int'(win_d) + 1) % N_REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      ptr_q   <= '0;
    end else if (!(state_q == OWNED && keep)) begin
      if (found) begin
        state_q <= OWNED;
        grant_q <= N_REQ'(1) << win_d;
        valid_q <= 1'b1;
        idx_q   <= win_d;
        ptr_q   <= ptr_d;
      end else begin
        state_q <= IDLE;
        grant_q <= '0;
        valid_q <= 1'b0;
      end
    end
  end

  assign grant       = grant_q;
  assign grant_valid = valid_q;
  assign grant_idx   = idx_q;

endmodule
